// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, reads instruction memory
// over a req/ack handshake and presents each word with its PC through a
// one-entry valid/ready buffer. Taken branches/jumps restart fetch at a new PC.
//
// Optional feature macro: FETCH_FLUSH_CNT_EN
//   defined   -> adds output flush_count, a saturating count of redirect cycles
//   undefined -> port and counter absent
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no request outstanding, buffer empty
// S_REQ  | imem_req high, waiting for imem_ack
// S_HOLD | buffer full, waiting for inst_ready
//
// A handed-off word passes through S_IDLE for one cycle before the next
// request, giving one instruction every three cycles with zero-wait memory.
// A redirect that arrives while a request is held cannot move imem_addr, so
// the target is parked in r_pend_pc and the in-flight data is dropped on ack.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_FLUSH_CNT_EN
    ,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_pc,        w_pc_nxt;
    logic [ADDR_W-1:0] r_pend_pc,   w_pend_pc_nxt;
    logic              r_discard,   w_discard_nxt;
    logic [31:0]       r_inst,      w_inst_nxt;
    logic [ADDR_W-1:0] r_inst_pc,   w_inst_pc_nxt;
    logic              r_inst_valid, w_inst_valid_nxt;

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_discard    <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    // Next-state and datapath decisions; redirect outranks every other event.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_discard_nxt    = r_discard;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_pc_nxt         = redirect_pc;
                    w_inst_valid_nxt = 1'b0;
                end
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        w_pc_nxt      = redirect_pc;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_pend_pc_nxt = redirect_pc;
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (r_discard) begin
                        w_pc_nxt      = r_pend_pc;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_inst_nxt       = imem_rdata;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + ADDR_W'(1);
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt         = redirect_pc;
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_REQ;
                end else if (inst_ready) begin
                    w_inst_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

`ifdef FETCH_FLUSH_CNT_EN
    logic [15:0] r_flush_count;

    // Count cycles with redirect asserted, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_count <= '0;
        end else if (redirect && (r_flush_count != 16'hFFFF)) begin
            r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch timing, stalls, redirects and PC
// wrap, followed by a randomized run scored against a stream-level model:
// accepted words must follow the PC stream that restarts at each redirect.
module tb_fetch_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              ack_en = 1'b0;
`ifdef FETCH_FLUSH_CNT_EN
    logic [15:0]       flush_count;
`endif

    int checks = 0;
    int failures = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_FLUSH_CNT_EN
        ,
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory: answers in any cycle the bench enables; data encodes the address.
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = 32'h1000_0000 + 32'(imem_addr);

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_hold;
    logic              redir_last;
    int                xfers;

    initial begin
        // ---------------- reset values ----------------
        inst_ready = 1'b1;
        ack_en     = 1'b1;
        repeat (3) nx();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 16'h0000);
        chk("rst_valid", inst_valid, 1'b0);
        rst_n = 1'b1;

        // ---------------- zero-wait stream ----------------
        nx(); chk("s_req0", imem_req, 1'b1); chk("s_addr0", imem_addr, 16'h0000);
        chk("s_valid_a", inst_valid, 1'b0);
        nx(); chk("s_valid_b", inst_valid, 1'b1); chk("s_inst0", inst, 32'h1000_0000);
        chk("s_pc0", inst_pc, 16'h0000); chk("s_req_hold", imem_req, 1'b0);
        nx(); chk("s_valid_c", inst_valid, 1'b0); chk("s_req_idle", imem_req, 1'b0);
        nx(); chk("s_req1", imem_req, 1'b1); chk("s_addr1", imem_addr, 16'h0001);
        chk("s_valid_d", inst_valid, 1'b0);
        nx(); chk("s_valid_e", inst_valid, 1'b1); chk("s_inst1", inst, 32'h1000_0001);
        chk("s_pc1", inst_pc, 16'h0001);
        nx(); chk("s_valid_f", inst_valid, 1'b0);
        nx(); chk("s_addr2", imem_addr, 16'h0002); chk("s_req2", imem_req, 1'b1);

        // ---------------- decode stall for 5 cycles ----------------
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nx();
            chk("st_valid", inst_valid, 1'b1);
            chk("st_pc", inst_pc, 16'h0002);
            chk("st_inst", inst, 32'h1000_0002);
            chk("st_req", imem_req, 1'b0);
        end
        inst_ready = 1'b1;
        nx(); chk("st_release", inst_valid, 1'b0);
        nx(); chk("st_next_req", imem_req, 1'b1); chk("st_next_addr", imem_addr, 16'h0003);

        // ---------------- redirect in HOLD with ready ----------------
        nx(); chk("rh_valid", inst_valid, 1'b1); chk("rh_pc", inst_pc, 16'h0003);
        redirect = 1'b1; redirect_pc = 16'h0040;
        nx(); redirect = 1'b0;
        chk("rh_dropped", inst_valid, 1'b0);
        chk("rh_req", imem_req, 1'b1); chk("rh_addr", imem_addr, 16'h0040);
        nx(); chk("rh_valid2", inst_valid, 1'b1); chk("rh_pc2", inst_pc, 16'h0040);
        chk("rh_inst2", inst, 32'h1000_0040);

        // ---------------- redirect during delayed ack ----------------
        ack_en = 1'b0;
        nx(); chk("rq_idle", inst_valid, 1'b0);
        nx(); chk("rq_req", imem_req, 1'b1); chk("rq_addr_a", imem_addr, 16'h0041);
        redirect = 1'b1; redirect_pc = 16'h0080;
        nx(); redirect = 1'b0;
        chk("rq_addr_b", imem_addr, 16'h0041); chk("rq_req_b", imem_req, 1'b1);
        nx(); chk("rq_addr_c", imem_addr, 16'h0041);
        redirect = 1'b1; redirect_pc = 16'h0090;
        nx(); redirect = 1'b0;
        chk("rq_addr_d", imem_addr, 16'h0041);
        ack_en = 1'b1;
        nx(); chk("rq_drop_valid", inst_valid, 1'b0);
        chk("rq_new_req", imem_req, 1'b1); chk("rq_new_addr", imem_addr, 16'h0090);
        nx(); chk("rq_valid", inst_valid, 1'b1); chk("rq_pc", inst_pc, 16'h0090);
        chk("rq_inst", inst, 32'h1000_0090);

        // ---------------- PC wrap ----------------
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        nx(); redirect = 1'b0;
        chk("w_addr", imem_addr, 16'hFFFF);
        nx(); chk("w_pc", inst_pc, 16'hFFFF); chk("w_inst", inst, 32'h1000_FFFF);
        nx();
        nx(); chk("w_req", imem_req, 1'b1); chk("w_addr_wrap", imem_addr, 16'h0000);

        // ---------------- redirect coincident with ack ----------------
        redirect = 1'b1; redirect_pc = 16'h0123;
        nx(); redirect = 1'b0;
        chk("ra_valid", inst_valid, 1'b0);
        chk("ra_req", imem_req, 1'b1); chk("ra_addr", imem_addr, 16'h0123);
        nx(); chk("ra_pc", inst_pc, 16'h0123); chk("ra_inst", inst, 32'h1000_0123);

        // ---------------- async reset mid-request ----------------
        nx();
        nx(); chk("ar_req_pre", imem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", imem_req, 1'b0); chk("ar_addr", imem_addr, 16'h0000);
        chk("ar_valid", inst_valid, 1'b0); chk("ar_inst", inst, 32'h0);

        // ---------------- randomized run ----------------
        inst_ready = 1'b0; ack_en = 1'b0; redirect = 1'b0;
        repeat (3) nx();
        rst_n = 1'b1;
        exp_pc = 16'h0000; prev_hold = 1'b0; prev_addr = '0; redir_last = 1'b0; xfers = 0;
        for (int c = 0; c < 3000; c++) begin
            nx();
            if (prev_hold) begin
                chk("r_req_held", imem_req, 1'b1);
                chk("r_addr_stable", imem_addr, prev_addr);
            end
            if (redir_last) chk("r_valid_after_redirect", inst_valid, 1'b0);
            ack_en      = ($urandom_range(0, 2) != 0);
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ADDR_W'($urandom);
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                chk("r_inst_pc", inst_pc, exp_pc);
                chk("r_inst", inst, mem_word(exp_pc));
                exp_pc = exp_pc + 16'd1;
                xfers++;
            end
            prev_hold  = imem_req && !ack_en;
            prev_addr  = imem_addr;
            redir_last = redirect;
        end
        chk("r_liveness", 32'(xfers > 100), 32'd1);
        redirect = 1'b0;

`ifdef FETCH_FLUSH_CNT_EN
        // ---------------- flush counter ----------------
        rst_n = 1'b0;
        nx();
        chk("fc_reset", flush_count, 16'h0000);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            redirect = 1'b1; nx();
            redirect = 1'b0; nx();
        end
        redirect = 1'b1; nx(); nx();
        redirect = 1'b0; nx();
        chk("fc_five", flush_count, 16'd5);
        redirect = 1'b1;
        repeat (65535) nx();
        redirect = 1'b0; nx();
        chk("fc_sat", flush_count, 16'hFFFF);
        redirect = 1'b1; nx();
        redirect = 1'b0; nx();
        chk("fc_sat_hold", flush_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
